// File: rtl/ram2p_fifo_ctrl_if.sv
// Stream and RAM-side signal bundle for ram2p_fifo_ctrl.
// slave: the FIFO controller. master: producer, consumer and RAM around it.
interface ram2p_fifo_ctrl_if #(
    parameter int unsigned AWID = 8,
    parameter int unsigned DWID = 16
);
    logic            i_wr_valid;
    logic            o_wr_ready;
    logic [DWID-1:0] i_wr_data;
    logic            o_rd_valid;
    logic            i_rd_ready;
    logic [DWID-1:0] o_rd_data;
    logic [AWID+1:0] o_count;
    logic            o_ram_wea;
    logic [AWID-1:0] o_ram_addra;
    logic [DWID-1:0] o_ram_data;
    logic [AWID-1:0] o_ram_addrb;
    logic [DWID-1:0] i_ram_datb;

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready, i_ram_datb,
        output o_wr_ready, o_rd_valid, o_rd_data, o_count,
        output o_ram_wea, o_ram_addra, o_ram_data, o_ram_addrb
    );

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready, i_ram_datb,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_count,
        input  o_ram_wea, o_ram_addra, o_ram_data, o_ram_addrb
    );
endinterface

// File: rtl/ram2p_fifo_ctrl.sv
// FWFT stream FIFO controller around an external dual-port RAM.
// Port A takes writes, port B reads into a two-entry head/skid output stage
// so a registered RAM read still sustains one word per cycle.
module ram2p_fifo_ctrl #(
    parameter int unsigned AWID = 8,
    parameter int unsigned DWID = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram2p_fifo_ctrl_if.slave       bus
);
    localparam logic [AWID:0] FULL_WORDS = {1'b1, {AWID{1'b0}}};

    logic [AWID:0]   wptr, rptr, ram_words;
    logic            init_done, inflight;
    logic [1:0]      occ, occ_after_pop;
    logic [2:0]      stage_load;
    logic [DWID-1:0] head, skid;
    logic            wr_fire, pop, issue;

    assign ram_words = wptr - rptr;

    // Write side: full only looks at RAM occupancy, not the output stage.
    assign bus.o_wr_ready  = init_done && (ram_words != FULL_WORDS);
    assign wr_fire         = bus.i_wr_valid && bus.o_wr_ready;
    assign bus.o_ram_wea   = wr_fire;
    assign bus.o_ram_addra = wptr[AWID-1:0];
    assign bus.o_ram_data  = bus.i_wr_data;

    // Read side: only issue when the word is guaranteed a stage slot on arrival.
    // rptr != wptr also keeps port B away from the address port A writes.
    assign pop             = bus.o_rd_valid && bus.i_rd_ready;
    assign stage_load      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue           = (ram_words != '0) && (stage_load < 3'd2);
    assign occ_after_pop   = occ - {1'b0, pop};
    assign bus.o_ram_addrb = rptr[AWID-1:0];

    assign bus.o_rd_valid  = (occ != 2'd0);
    assign bus.o_rd_data   = head;
    assign bus.o_count     = {1'b0, ram_words} + {{(AWID+1){1'b0}}, inflight}
                           + {{AWID{1'b0}}, occ};

    // Write enable is held off for one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_done <= 1'b0;
        else        init_done <= 1'b1;
    end

    // Pointers advance on accepted writes and issued reads; inflight marks a read in the RAM pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr_fire) wptr <= wptr + 1'b1;
            if (issue)   rptr <= rptr + 1'b1;
            inflight <= issue;
        end
    end

    // Output stage: pop shifts skid into head, arriving RAM data fills the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
            occ  <= 2'd0;
        end else begin
            if (pop && (occ == 2'd2)) head <= skid;
            if (inflight) begin
                if (occ_after_pop == 2'd0) head <= bus.i_ram_datb;
                else                       skid <= bus.i_ram_datb;
            end
            occ <= occ_after_pop + {1'b0, inflight};
        end
    end
endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// Self-checking bench for ram2p_fifo_ctrl with a behavioural RAM and a queue scoreboard.
module tb_ram2p_fifo_ctrl;
    localparam int unsigned AWID  = 3;
    localparam int unsigned DWID  = 16;
    localparam int unsigned DEPTH = 1 << AWID;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram2p_fifo_ctrl_if #(.AWID(AWID), .DWID(DWID)) bus ();

    ram2p_fifo_ctrl #(.AWID(AWID), .DWID(DWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // RAM model: synchronous write on A, registered read on B.
    logic [DWID-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.o_ram_wea) mem[bus.o_ram_addra] <= bus.o_ram_data;
        bus.i_ram_datb <= mem[bus.o_ram_addrb];
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; count = accepted minus popped since reset.
    logic [DWID-1:0] exp_q[$];
    int              model_count = 0;

    // Monitor: handshakes seen at the falling edge take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_count = 0;
            check("reset rd_valid", 32'(bus.o_rd_valid), 32'd0);
            check("reset count", 32'(bus.o_count), 32'd0);
        end else begin
            check("count", 32'(bus.o_count), 32'(model_count));
            if (bus.o_rd_valid && bus.i_rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL pop_on_empty: got data 0x%0h, expected no word", bus.o_rd_data);
                end else begin
                    check("rd_data", 32'(bus.o_rd_data), 32'(exp_q.pop_front()));
                    model_count--;
                end
            end
            if (bus.i_wr_valid && bus.o_wr_ready) begin
                exp_q.push_back(bus.i_wr_data);
                model_count++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        bus.i_wr_valid = 1'b0;
        bus.i_rd_ready = 1'b1;
        repeat (cycles) cyc();
        bus.i_rd_ready = 1'b0;
        @(negedge clk);
        check("drained count", 32'(bus.o_count), 32'd0);
        check("drained rd_valid", 32'(bus.o_rd_valid), 32'd0);
        cyc();
    endtask

    logic acc;
    int   accepted;
    int   cycles;

    initial begin
        rst_n          = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 16'h5A3C;
        bus.i_rd_ready = 1'b0;

        // Reset state, with a pending write that must be refused.
        repeat (3) begin
            @(negedge clk);
            check("rst wr_ready", 32'(bus.o_wr_ready), 32'd0);
            check("rst rd_data", 32'(bus.o_rd_data), 32'd0);
            check("rst ram_wea", 32'(bus.o_ram_wea), 32'd0);
            check("rst addra", 32'(bus.o_ram_addra), 32'd0);
            check("rst addrb", 32'(bus.o_ram_addrb), 32'd0);
            check("rst ram_data", 32'(bus.o_ram_data), 32'h5A3C);
        end
        cyc();
        rst_n          = 1'b1;
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        check("release wr_ready early", 32'(bus.o_wr_ready), 32'd0);
        cyc();
        @(negedge clk);
        check("release wr_ready", 32'(bus.o_wr_ready), 32'd1);
        check("release rd_valid", 32'(bus.o_rd_valid), 32'd0);
        cyc();

        // Single word: visible at the head three cycles after acceptance.
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 16'hA5A5;
        cyc();
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        check("single c1 rd_valid", 32'(bus.o_rd_valid), 32'd0);
        check("single c1 count", 32'(bus.o_count), 32'd1);
        cyc();
        @(negedge clk);
        check("single c2 rd_valid", 32'(bus.o_rd_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("single c3 rd_valid", 32'(bus.o_rd_valid), 32'd1);
        check("single c3 rd_data", 32'(bus.o_rd_data), 32'hA5A5);
        drain(3);

        // Fill with no consumer: RAM full plus two words parked in the output stage.
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc = bus.o_wr_ready;
            cyc();
            if (acc) bus.i_wr_data = bus.i_wr_data + 16'd1;
        end
        check("fill accepted", 32'(bus.i_wr_data), 32'(DEPTH + 2));
        @(negedge clk);
        check("full wr_ready", 32'(bus.o_wr_ready), 32'd0);
        check("full count", 32'(bus.o_count), 32'(DEPTH + 2));
        check("full head", 32'(bus.o_rd_data), 32'h0000);
        check("full ram_wea", 32'(bus.o_ram_wea), 32'd0);
        cyc();
        drain(DEPTH + 6);

        // Streaming: gap-free reads after the fill latency, steady occupancy of 3.
        bus.i_wr_valid = 1'b1;
        bus.i_rd_ready = 1'b1;
        bus.i_wr_data  = 16'h0100;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                check("stream rd_valid", 32'(bus.o_rd_valid), 32'd1);
                check("stream count", 32'(bus.o_count), 32'd3);
            end
            acc = bus.o_wr_ready;
            cyc();
            if (acc) bus.i_wr_data = bus.i_wr_data + 16'd1;
        end
        drain(8);

        // Random backpressure on both sides; pointers wrap many times.
        accepted      = 0;
        cycles        = 0;
        bus.i_wr_data = 16'($urandom);
        while (accepted < 10000 && cycles < 60000) begin
            bus.i_wr_valid = 1'($urandom_range(0, 1));
            bus.i_rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.i_wr_valid && bus.o_wr_ready;
            cyc();
            cycles++;
            if (acc) begin
                accepted++;
                bus.i_wr_data = 16'($urandom);
            end
        end
        check("random words within budget", 32'(accepted >= 10000), 32'd1);
        drain(DEPTH + 6);

        // Reset while a read is in flight and the head is occupied.
        bus.i_wr_valid = 1'b1;
        bus.i_rd_ready = 1'b0;
        bus.i_wr_data  = 16'hC000;
        repeat (3) begin
            cyc();
            bus.i_wr_data = bus.i_wr_data + 16'd1;
        end
        check("pre-reset rd_valid", 32'(bus.o_rd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset rd_valid", 32'(bus.o_rd_valid), 32'd0);
        check("midreset count", 32'(bus.o_count), 32'd0);
        bus.i_wr_valid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 16'h1234;
        cyc();
        bus.i_wr_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("post-reset rd_valid", 32'(bus.o_rd_valid), 32'd1);
        check("post-reset rd_data", 32'(bus.o_rd_data), 32'h1234);
        check("post-reset count", 32'(bus.o_count), 32'd1);
        cyc();
        drain(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
